// File: rtl/qupls4_msi_mport_arbiter_if.sv
// ---------------------------------------------------------------------------
// FTA 256-bit command/response types and the bundled port interface for the
// MSI master-port arbiter.
//
// fta_bus_pkg
//   fta_cmd_request256_t   single-beat master request (cmd, cyc/stb/we, sel,
//                          tid, padr, data1)
//   fta_cmd_response256_t  master response (tid, ack, rty, err, adr, dat)
//
// qupls4_msi_mport_arbiter_if #(NREQ)
//   req_i   [NREQ]  requester commands (cyc held until granted)
//   gnt_o   NREQ    accept pulse per requester
//   done_o  NREQ    completion pulse per requester
//   drop_o  NREQ    abandon pulse per requester (retry limit reached)
//   resp_o  [NREQ]  per-requester copy of the master response, ack TID-gated
//   mreq_o          shared master request
//   mresp_i         shared master response
//   busy_o          arbiter not idle
//   modport master : the arbiter side
//   modport slave  : requesters + bus side
// ---------------------------------------------------------------------------
package fta_bus_pkg;

  typedef enum logic [4:0] {
    CMD_NONE  = 5'd0,
    CMD_LOAD  = 5'd1,
    CMD_STORE = 5'd2
  } fta_cmd_t;

  typedef struct packed {
    logic [7:0]   tid;
    fta_cmd_t     cmd;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [31:0]  sel;
    logic [31:0]  padr;
    logic [255:0] data1;
  } fta_cmd_request256_t;

  typedef struct packed {
    logic [7:0]   tid;
    logic         ack;
    logic         rty;
    logic         err;
    logic [31:0]  adr;
    logic [255:0] dat;
  } fta_cmd_response256_t;

endpackage

interface qupls4_msi_mport_arbiter_if #(
  parameter int NREQ = 4
) ();
  import fta_bus_pkg::*;

  fta_cmd_request256_t  req_i  [NREQ];
  logic [NREQ-1:0]      gnt_o;
  logic [NREQ-1:0]      done_o;
  logic [NREQ-1:0]      drop_o;
  fta_cmd_response256_t resp_o [NREQ];
  fta_cmd_request256_t  mreq_o;
  fta_cmd_response256_t mresp_i;
  logic                 busy_o;

  modport master (
    input  req_i, mresp_i,
    output gnt_o, done_o, drop_o, resp_o, mreq_o, busy_o
  );

  modport slave (
    output req_i, mresp_i,
    input  gnt_o, done_o, drop_o, resp_o, mreq_o, busy_o
  );

endinterface

// File: rtl/qupls4_msi_mport_arbiter.sv
// ---------------------------------------------------------------------------
// qupls4_msi_mport_arbiter
// Shares one 256-bit FTA master port between NREQ single-beat writers
// (MSI logger, IMSIC log/ack paths). One transaction is in flight at a time;
// a request answered with rty is reissued after a backoff, and dropped after
// RTY_LIMIT reissues. Responses are fanned out to every requester with ack
// qualified by the TID each requester last had granted.
//
// Ports
//   clk   clock
//   rst   synchronous active-high reset
//   bus   qupls4_msi_mport_arbiter_if.master (req_i, gnt_o, done_o, drop_o,
//         resp_o, mreq_o, mresp_i, busy_o)
//
// Parameters
//   NREQ       number of requesters (2..8)
//   RTY_WAIT   backoff cycles between an rty response and the reissue (>=1)
//   RTY_LIMIT  reissues before the request is dropped
//
// Build option
//   MSI_ARB_FIXED_PRI_EN  when defined, fixed priority (lowest index wins,
//                         rotation pointer held at 0); otherwise round-robin.
// ---------------------------------------------------------------------------
module qupls4_msi_mport_arbiter
  import fta_bus_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int RTY_WAIT  = 31,
  parameter int RTY_LIMIT = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  qupls4_msi_mport_arbiter_if.master bus
);

  localparam int              IW          = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]      RTY_LIMIT_C = 4'(RTY_LIMIT);
  // Last backoff cycle: ISSUE follows exactly RTY_WAIT+1 cycles after CHECK.
  localparam logic [5:0]      WAIT_LAST_C = 6'(RTY_WAIT - 1);
  localparam logic [IW-1:0]   LAST_IDX_C  = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CHECK,
    ST_BACKOFF
  } state_t;

  state_t              state_q;
  fta_cmd_request256_t mreq_q;
  fta_cmd_request256_t hold_q;
  logic [NREQ-1:0]     gnt_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [IW-1:0]       owner_q;
  logic [3:0]          rty_cnt_q;
  logic [5:0]          wait_cnt_q;
  logic [7:0]          tid_tab_q [NREQ];

  logic                pick_vld_d;
  logic [IW-1:0]       pick_idx_d;
  logic [IW-1:0]       rr_next_d;
  logic                chk_d;
  logic                last_try_d;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  function automatic fta_cmd_request256_t drive_req(input fta_cmd_request256_t r);
    drive_req     = r;
    drive_req.cyc = 1'b1;
    drive_req.stb = 1'b1;
  endfunction

  function automatic fta_cmd_response256_t route_resp(
    input fta_cmd_response256_t m,
    input logic [7:0]           tid,
    input logic                 r
  );
    route_resp     = m;
    route_resp.ack = m.ack & (m.tid == tid);
    if (r) route_resp = '0;
  endfunction

  // First requester with cyc at or after the rotation pointer.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_vld_d && bus.req_i[IW'((int'(rr_ptr_q) + k) % NREQ)].cyc) begin
        pick_vld_d = 1'b1;
        pick_idx_d = IW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

`ifdef MSI_ARB_FIXED_PRI_EN
  assign rr_next_d = '0;
`else
  assign rr_next_d = (owner_q == LAST_IDX_C) ? '0 : owner_q + IW'(1);
`endif

  // done/drop are decided in the CHECK cycle itself from the live response.
  assign chk_d      = (state_q == ST_CHECK) && !rst;
  assign last_try_d = (rty_cnt_q == RTY_LIMIT_C);

  assign bus.mreq_o = mreq_q;
  assign bus.gnt_o  = gnt_q;
  assign bus.busy_o = (state_q != ST_IDLE);
  assign bus.done_o = (chk_d && !bus.mresp_i.rty) ? onehot(owner_q) : '0;
  assign bus.drop_o = (chk_d && bus.mresp_i.rty && last_try_d) ? onehot(owner_q) : '0;

  for (genvar g = 0; g < NREQ; g++) begin : g_resp
    assign bus.resp_o[g] = route_resp(bus.mresp_i, tid_tab_q[g], rst);
  end

  // hold_q is pure data and is only ever read after being loaded in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mreq_q     <= '0;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      rty_cnt_q  <= '0;
      wait_cnt_q <= '0;
      tid_tab_q  <= '{default: '0};
    end else begin
      gnt_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld_d) begin
            hold_q                <= bus.req_i[pick_idx_d];
            owner_q               <= pick_idx_d;
            tid_tab_q[pick_idx_d] <= bus.req_i[pick_idx_d].tid;
            gnt_q                 <= onehot(pick_idx_d);
            rty_cnt_q             <= '0;
            mreq_q                <= drive_req(bus.req_i[pick_idx_d]);
            state_q               <= ST_ISSUE;
          end else begin
            mreq_q <= '0;
          end
        end
        ST_ISSUE: begin
          mreq_q  <= '0;
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          // rty outranks a simultaneous ack.
          if (!bus.mresp_i.rty || last_try_d) begin
            rr_ptr_q <= rr_next_d;
            state_q  <= ST_IDLE;
          end else begin
            rty_cnt_q  <= rty_cnt_q + 4'd1;
            wait_cnt_q <= '0;
            state_q    <= ST_BACKOFF;
          end
        end
        ST_BACKOFF: begin
          wait_cnt_q <= wait_cnt_q + 6'd1;
          if (wait_cnt_q == WAIT_LAST_C) begin
            mreq_q  <= drive_req(hold_q);
            state_q <= ST_ISSUE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
